// File: rtl/lw_sha_core_arbiter_if.sv
// Bundle between the requesters, the session arbiter and the shared lw_hmac core.
// The slave modport is the arbiter's view; master is the view of whatever drives requests and core status.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

interface lw_sha_core_arbiter_if #(
    parameter int NREQ      = 2,
    parameter int WORD_SIZE = `WORD_SIZE
);
    logic [NREQ-1:0]           req_i;
    logic [4*NREQ-1:0]         req_opcode_i;
    logic [NREQ-1:0]           req_valid_i;
    logic [WORD_SIZE*NREQ-1:0] req_data_i;
    logic [NREQ-1:0]           req_last_i;
    logic [NREQ-1:0]           req_ready_o;
    logic [NREQ-1:0]           done_o;
    logic [NREQ-1:0]           err_o;
    logic [NREQ-1:0]           grant_o;
    logic                      busy_o;

    logic                      start_o;
    logic                      valid_o;
    logic                      last_o;
    logic                      abort_o;
    logic [3:0]                opcode_o;
    logic [WORD_SIZE-1:0]      data_o;
    logic                      ready_i;
    logic                      done_i;
    logic                      fault_inj_det_i;

    modport slave (
        input  req_i, req_opcode_i, req_valid_i, req_data_i, req_last_i,
        input  ready_i, done_i, fault_inj_det_i,
        output req_ready_o, done_o, err_o, grant_o, busy_o,
        output start_o, valid_o, last_o, abort_o, opcode_o, data_o
    );

    modport master (
        output req_i, req_opcode_i, req_valid_i, req_data_i, req_last_i,
        output ready_i, done_i, fault_inj_det_i,
        input  req_ready_o, done_o, err_o, grant_o, busy_o,
        input  start_o, valid_o, last_o, abort_o, opcode_o, data_o
    );
endinterface

// File: rtl/lw_sha_core_arbiter.sv
// Round-robin session arbiter sharing one lw_hmac core among NREQ requesters.
// A session is grant -> start pulse -> word stream -> wait for core done, with timeout and fault abort.
//
// state       | meaning
// S_IDLE      | no owner; arbitrate among pending req_i
// S_START     | one-cycle start_o with captured opcode
// S_STREAM    | owner's words pass through to the core
// S_WAIT_DONE | last word sent; wait for done_i or timeout
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module lw_sha_core_arbiter #(
    parameter int NREQ      = 2,
    parameter int WORD_SIZE = `WORD_SIZE,
    parameter int TIMEOUT   = 1024
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    lw_sha_core_arbiter_if.slave   bus
);
    localparam int OW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_STREAM    = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   r_last_grant;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_done;
    logic [NREQ-1:0] r_err;
    logic            r_start;
    logic            r_abort;
    logic [3:0]      r_opcode;
    logic [TW-1:0]   r_timer;

    logic                 w_found;
    logic [OW-1:0]        w_winner;
    logic [NREQ-1:0]      w_win_onehot;
    logic                 w_valid;
    logic                 w_last;
    logic [WORD_SIZE-1:0] w_data;
    logic [NREQ-1:0]      w_req_ready;
    logic                 w_fault;
    logic                 w_drop;
    logic                 w_done_ev;
    logic                 w_tmo;
    logic                 w_end_err;
    logic                 w_end_abort;
    logic                 w_end_ok;
    logic                 w_end;
    logic                 w_xfer_last;

    // Search upward from the previous owner so every requester gets a turn.
    always_comb begin
        w_found      = 1'b0;
        w_winner     = '0;
        w_win_onehot = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!w_found && bus.req_i[(int'(r_last_grant) + i) % NREQ]) begin
                w_found  = 1'b1;
                w_winner = OW'((int'(r_last_grant) + i) % NREQ);
            end
        end
        w_win_onehot[w_winner] = 1'b1;
    end

    always_comb begin
        w_valid     = 1'b0;
        w_last      = 1'b0;
        w_data      = '0;
        w_req_ready = '0;
        if (r_state == S_STREAM) begin
            w_valid              = bus.req_valid_i[r_owner];
            w_last               = bus.req_last_i[r_owner];
            w_data               = bus.req_data_i[r_owner*WORD_SIZE +: WORD_SIZE];
            w_req_ready[r_owner] = bus.ready_i;
        end
    end

    // Session-ending events; fault beats done, done beats timeout.
    always_comb begin
        w_fault     = (r_state != S_IDLE) && bus.fault_inj_det_i;
        w_drop      = ((r_state == S_START) || (r_state == S_STREAM)) && !bus.req_i[r_owner];
        w_done_ev   = (r_state == S_WAIT_DONE) && bus.done_i;
        w_tmo       = (r_state == S_WAIT_DONE) && (r_timer == TMAX);
        w_end_err   = w_fault || (w_tmo && !w_done_ev);
        w_end_abort = w_end_err || w_drop;
        w_end_ok    = w_done_ev && !w_fault;
        w_end       = w_end_abort || w_end_ok;
        w_xfer_last = w_valid && bus.ready_i && w_last;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= S_IDLE;
            r_owner      <= '0;
            r_last_grant <= OW'(NREQ - 1);
            r_grant      <= '0;
            r_done       <= '0;
            r_err        <= '0;
            r_start      <= 1'b0;
            r_abort      <= 1'b0;
            r_opcode     <= '0;
            r_timer      <= '0;
        end else begin
            r_start <= 1'b0;
            r_abort <= 1'b0;
            r_done  <= '0;
            r_err   <= '0;
            if (w_end) begin
                r_state      <= S_IDLE;
                r_last_grant <= r_owner;
                r_grant      <= '0;
                r_opcode     <= '0;
                r_timer      <= '0;
                r_abort      <= w_end_abort;
                r_done       <= w_end_ok  ? r_grant : '0;
                r_err        <= w_end_err ? r_grant : '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_found) begin
                            r_state  <= S_START;
                            r_owner  <= w_winner;
                            r_grant  <= w_win_onehot;
                            r_opcode <= bus.req_opcode_i[w_winner*4 +: 4];
                            r_start  <= 1'b1;
                        end
                    end
                    S_START: begin
                        r_state <= S_STREAM;
                    end
                    S_STREAM: begin
                        if (w_xfer_last) begin
                            r_state <= S_WAIT_DONE;
                            r_timer <= '0;
                        end
                    end
                    S_WAIT_DONE: begin
                        if (r_timer != TMAX) begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.req_ready_o = w_req_ready;
    assign bus.done_o      = r_done;
    assign bus.err_o       = r_err;
    assign bus.grant_o     = r_grant;
    assign bus.busy_o      = (r_state != S_IDLE);
    assign bus.start_o     = r_start;
    assign bus.abort_o     = r_abort;
    assign bus.opcode_o    = r_opcode;
    assign bus.valid_o     = w_valid;
    assign bus.last_o      = w_last;
    assign bus.data_o      = w_data;
endmodule

// File: tb/tb_lw_sha_core_arbiter.sv
// Bench for lw_sha_core_arbiter: NREQ=2, 32-bit words, TIMEOUT=16.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module tb_lw_sha_core_arbiter;
    localparam int NREQ = 2;
    localparam int WS   = 32;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   xfer_cnt = 0;

    typedef struct {
        logic [WS-1:0] data;
        logic          last;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic          valid;
        logic          last;
        logic          ready;
        logic [WS-1:0] data;
        logic          exp_valid;
        logic [1:0]    exp_ready;
        logic          exp_last;
    } vec_t;

    lw_sha_core_arbiter_if #(.NREQ(NREQ), .WORD_SIZE(WS)) bus ();

    lw_sha_core_arbiter #(.NREQ(NREQ), .WORD_SIZE(WS), .TIMEOUT(16)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
            xfer_cnt++;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_xfer", 1, 0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("xfer_data", bus.data_o, e.data);
                check("xfer_last", bus.last_o, e.last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_phase(input int r, input logic [3:0] op);
        logic [1:0] oh;
        oh = 2'b00;
        oh[r] = 1'b1;
        tick();
        check("grant", bus.grant_o, oh);
        check("start_hi", bus.start_o, 1);
        check("opcode", bus.opcode_o, op);
        check("busy_start", bus.busy_o, 1);
        check("done_clear", bus.done_o, 0);
        tick();
        check("start_one_cycle", bus.start_o, 0);
    endtask

    task automatic stream_phase(input int r, input int n, input bit toggle, input bit with_last);
        int  i = 0;
        int  c = 0;
        bit  rdy;
        sb_t e;
        xfer_cnt = 0;
        while (i < n && c < 200) begin
            rdy    = toggle ? (c % 2 == 0) : 1'b1;
            e.data = 32'hC0DE_0000 | 32'(r << 12) | 32'(i);
            e.last = with_last && (i == n - 1);
            bus.req_valid_i[r]         = 1'b1;
            bus.req_data_i[r*WS +: WS] = e.data;
            bus.req_last_i[r]          = e.last;
            bus.ready_i                = rdy;
            if (rdy) sb_q.push_back(e);
            tick();
            if (rdy) i++;
            c++;
        end
        check("stream_words", xfer_cnt, n);
        if (with_last) begin
            bus.ready_i = 1'b1;
            #1;
            check("wait_valid_low", bus.valid_o, 0);
            check("wait_last_low", bus.last_o, 0);
            check("wait_ready_low", bus.req_ready_o, 0);
            check("wait_busy", bus.busy_o, 1);
        end
        bus.req_valid_i[r] = 1'b0;
        bus.req_last_i[r]  = 1'b0;
        bus.ready_i        = 1'b0;
    endtask

    task automatic done_phase(input int r);
        logic [1:0] oh;
        oh = 2'b00;
        oh[r] = 1'b1;
        bus.done_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
        check("done_pulse", bus.done_o, oh);
        check("done_no_err", bus.err_o, 0);
        check("done_no_abort", bus.abort_o, 0);
        check("done_idle", bus.busy_o, 0);
        check("done_grant0", bus.grant_o, 0);
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'hC0DE_1000, 1'b1, 2'b00, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'hC0DE_1000, 1'b1, 2'b10, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 2'b10, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 32'hC0DE_1001, 1'b1, 2'b10, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'hC0DE_1002, 1'b0, 2'b00, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'hC0DE_1002, 1'b1, 2'b10, 1'b1};

        rst                 = 1'b1;
        bus.req_i           = 2'b11;
        bus.req_opcode_i    = {4'hA, 4'h5};
        bus.req_valid_i     = '0;
        bus.req_data_i      = '0;
        bus.req_last_i      = '0;
        bus.ready_i         = 1'b0;
        bus.done_i          = 1'b0;
        bus.fault_inj_det_i = 1'b0;
        tick();
        tick();
        check("rst_grant", bus.grant_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_start", bus.start_o, 0);
        check("rst_done_err", {bus.done_o, bus.err_o, bus.abort_o}, 0);
        check("rst_stream", {bus.valid_o, bus.last_o, bus.req_ready_o}, 0);
        check("rst_opcode", bus.opcode_o, 0);
        check("rst_data", bus.data_o, 0);

        // round robin over four back-to-back sessions with both requesting
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            start_phase(s % 2, (s % 2 == 0) ? 4'h5 : 4'hA);
            stream_phase(s % 2, 2, 1'b0, 1'b1);
            done_phase(s % 2);
        end
        bus.req_i = 2'b00;
        tick();
        check("idle_no_rearb", {bus.busy_o, bus.grant_o}, 0);

        // requester 0, opcode 3, 16 words with ready toggling
        bus.req_opcode_i[3:0] = 4'h3;
        bus.req_i = 2'b01;
        start_phase(0, 4'h3);
        stream_phase(0, 16, 1'b1, 1'b1);
        tick();
        check("wait_no_early_done", bus.done_o, 0);
        done_phase(0);
        bus.req_i = 2'b00;
        tick();
        check("done_one_cycle", bus.done_o, 0);
        bus.req_opcode_i[3:0] = 4'h5;

        // table-driven stream for requester 1 with junk on the idle lane
        bus.req_i = 2'b10;
        start_phase(1, 4'hA);
        bus.req_valid_i[0] = 1'b1;
        bus.req_last_i[0]  = 1'b1;
        bus.req_data_i[WS-1:0] = 32'hDEAD_BEEF;
        xfer_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            bus.req_valid_i[1]     = vecs[k].valid;
            bus.req_last_i[1]      = vecs[k].last;
            bus.ready_i            = vecs[k].ready;
            bus.req_data_i[WS +: WS] = vecs[k].data;
            #1;
            check("vec_valid", bus.valid_o, vecs[k].exp_valid);
            check("vec_ready", bus.req_ready_o, vecs[k].exp_ready);
            check("vec_last", bus.last_o, vecs[k].exp_last);
            check("vec_data", bus.data_o, vecs[k].data);
            if (vecs[k].valid && vecs[k].ready) sb_q.push_back('{vecs[k].data, vecs[k].last});
            tick();
        end
        check("vec_xfers", xfer_cnt, 3);
        check("vec_wait_last_low", {bus.valid_o, bus.last_o}, 0);
        bus.req_valid_i = '0;
        bus.req_last_i  = '0;
        bus.ready_i     = 1'b0;
        done_phase(1);
        bus.req_i = 2'b00;

        // timeout: no done_i after last word
        bus.req_i = 2'b01;
        start_phase(0, 4'h5);
        stream_phase(0, 2, 1'b0, 1'b1);
        for (int k = 1; k < 16; k++) begin
            tick();
            check("tmo_not_yet", {bus.err_o, bus.abort_o, ~bus.busy_o}, 0);
        end
        tick();
        check("tmo_err", bus.err_o, 2'b01);
        check("tmo_abort", bus.abort_o, 1);
        check("tmo_no_done", bus.done_o, 0);
        check("tmo_idle", bus.busy_o, 0);
        bus.req_i = 2'b00;
        tick();
        check("tmo_pulse_one_cycle", {bus.err_o, bus.abort_o}, 0);

        // done_i on the timeout cycle: done wins
        bus.req_i = 2'b10;
        start_phase(1, 4'hA);
        stream_phase(1, 1, 1'b0, 1'b1);
        for (int k = 1; k < 16; k++) tick();
        done_phase(1);
        bus.req_i = 2'b00;

        // fault with done_i: error wins
        bus.req_i = 2'b01;
        start_phase(0, 4'h5);
        stream_phase(0, 1, 1'b0, 1'b1);
        bus.done_i = 1'b1;
        bus.fault_inj_det_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
        bus.fault_inj_det_i = 1'b0;
        check("fault_err", bus.err_o, 2'b01);
        check("fault_abort", bus.abort_o, 1);
        check("fault_no_done", bus.done_o, 0);
        bus.req_i = 2'b00;

        // owner drops request after 3 words; pending requester 0 is next
        bus.req_i = 2'b11;
        start_phase(1, 4'hA);
        stream_phase(1, 3, 1'b0, 1'b0);
        bus.req_i[1] = 1'b0;
        tick();
        check("drop_abort", bus.abort_o, 1);
        check("drop_no_done_err", {bus.done_o, bus.err_o}, 0);
        check("drop_idle", bus.busy_o, 0);
        start_phase(0, 4'h5);
        bus.req_i[0] = 1'b0;
        tick();
        check("drop0_abort", bus.abort_o, 1);
        check("drop0_no_err", bus.err_o, 0);

        // reset in WAIT_DONE
        bus.req_i = 2'b01;
        start_phase(0, 4'h5);
        stream_phase(0, 1, 1'b0, 1'b1);
        rst = 1'b1;
        bus.done_i = 1'b1;
        tick();
        rst = 1'b0;
        bus.done_i = 1'b0;
        check("mrst_silent", {bus.done_o, bus.err_o, bus.abort_o}, 0);
        check("mrst_idle", {bus.busy_o, bus.grant_o, bus.start_o}, 0);
        bus.req_i = 2'b11;
        tick();
        check("mrst_grant_req0", bus.grant_o, 2'b01);
        bus.req_i = 2'b00;
        tick();

        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
